// File: rtl/conv_window_sched_if.sv
// Handshake bundle between the pixel source, the line-buffer ring
// and the 3x3 window consumer.
interface conv_window_sched_if #(
   parameter int IM_DIM  = 28,
   parameter int NUM_BUF = 4
);
   localparam int AW = $clog2(IM_DIM);

   logic               pix_valid_i;
   logic               pix_ready_o;
   logic [NUM_BUF-1:0] wr_en_o;
   logic [AW-1:0]      rd_address_o;
   logic [1:0]         rd_sel_o;
   logic               win_valid_o;
   logic               win_ready_i;
   logic [AW-1:0]      out_row_o;
   logic               frame_done_o;

   modport master (
      input  pix_valid_i,
      input  win_ready_i,
      output pix_ready_o,
      output wr_en_o,
      output rd_address_o,
      output rd_sel_o,
      output win_valid_o,
      output out_row_o,
      output frame_done_o
   );

   modport slave (
      output pix_valid_i,
      output win_ready_i,
      input  pix_ready_o,
      input  wr_en_o,
      input  rd_address_o,
      input  rd_sel_o,
      input  win_valid_o,
      input  out_row_o,
      input  frame_done_o
   );
endinterface

// File: rtl/conv_window_sched.sv
// Line-buffer ring scheduler: steers incoming pixels into one of four
// line buffers and walks 3x3 window positions over the three full ones.
module conv_window_sched #(
   parameter int INPUT_WIDTH = 8,
   parameter int IM_DIM      = 28,
   parameter int NUM_BUF     = 4
) (
   input  logic                clk_i,
   input  logic                reset,
   conv_window_sched_if.master bus
);
   localparam int AW = $clog2(IM_DIM);
   localparam logic [AW-1:0] ONE      = AW'(1);
   localparam logic [AW-1:0] COL_LAST = AW'(IM_DIM - 1);
   localparam logic [AW-1:0] WIN_LAST = AW'(IM_DIM - 3);
   localparam logic [NUM_BUF-1:0] OH0 =
      {{(NUM_BUF-1){1'b0}}, 1'b1};

   if (INPUT_WIDTH < 1 || IM_DIM < 4 || NUM_BUF != 4) begin : g_bad_cfg
      $error("conv_window_sched: unsupported parameters");
   end

   typedef enum logic {
      S_WAIT,
      S_STREAM
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    f_q, f_d;
   logic [1:0]    wr_ptr_q, wr_ptr_d;
   logic [1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] col_q, col_d;
   logic [AW-1:0] row_q, row_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW-1:0] out_row_q, out_row_d;
   logic          win_valid_q, win_valid_d;
   logic          frame_done_q, frame_done_d;

   logic          pix_ready;
   logic          accept;
   logic          line_done;
   logic          win_acc;
   logic          row_end;
   logic          frame_end;
   logic [2:0]    rel;

   always_comb begin
      pix_ready = (f_q < 3'd4);
      // Reset gates the write strobe so no buffer is touched mid-reset.
      accept    = bus.pix_valid_i & pix_ready & ~reset;
      line_done = accept & (col_q == COL_LAST);
      win_acc   = win_valid_q & bus.win_ready_i;
      row_end   = win_acc & (rd_addr_q == WIN_LAST);
      frame_end = row_end & (out_row_q == WIN_LAST);
      rel       = frame_end ? 3'd3 : (row_end ? 3'd1 : 3'd0);

      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      col_d        = col_q;
      row_d        = row_q;
      rd_addr_d    = rd_addr_q;
      out_row_d    = out_row_q;
      win_valid_d  = win_valid_q;
      frame_done_d = 1'b0;

      if (accept) begin
         col_d = line_done ? '0 : col_q + ONE;
      end
      if (line_done) begin
         wr_ptr_d = wr_ptr_q + 2'd1;
         row_d    = (row_q == COL_LAST) ? '0 : row_q + ONE;
      end
      f_d = f_q + {2'b00, line_done} - rel;

      unique case (state_q)
         S_WAIT: begin
            if (f_q >= 3'd3) begin
               state_d     = S_STREAM;
               win_valid_d = 1'b1;
               rd_addr_d   = '0;
            end
         end
         S_STREAM: begin
            if (row_end) begin
               state_d     = S_WAIT;
               win_valid_d = 1'b0;
               rd_addr_d   = '0;
               if (frame_end) begin
                  rd_ptr_d     = rd_ptr_q + 2'd3;
                  out_row_d    = '0;
                  frame_done_d = 1'b1;
               end else begin
                  rd_ptr_d  = rd_ptr_q + 2'd1;
                  out_row_d = out_row_q + ONE;
               end
            end else if (win_acc) begin
               rd_addr_d = rd_addr_q + ONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state_q      <= S_WAIT;
         f_q          <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         col_q        <= '0;
         row_q        <= '0;
         rd_addr_q    <= '0;
         out_row_q    <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         f_q          <= f_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         col_q        <= col_d;
         row_q        <= row_d;
         rd_addr_q    <= rd_addr_d;
         out_row_q    <= out_row_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.pix_ready_o  = pix_ready;
   assign bus.wr_en_o      = accept ? (OH0 << wr_ptr_q) : '0;
   assign bus.rd_address_o = rd_addr_q;
   assign bus.rd_sel_o     = rd_ptr_q;
   assign bus.win_valid_o  = win_valid_q;
   assign bus.out_row_o    = out_row_q;
   assign bus.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: fill timing, ring pointers,
// full frames, backpressure stall and asynchronous mid-row reset.
module tb_conv_window_sched;
   localparam int IM_DIM  = 28;
   localparam int NUM_BUF = 4;
   localparam int NWIN    = (IM_DIM - 2) * (IM_DIM - 2);
   localparam int NPIX    = IM_DIM * IM_DIM;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   conv_window_sched_if #(
      .IM_DIM (IM_DIM),
      .NUM_BUF(NUM_BUF)
   ) bus ();

   conv_window_sched #(
      .INPUT_WIDTH(8),
      .IM_DIM     (IM_DIM),
      .NUM_BUF    (NUM_BUF)
   ) dut (
      .clk_i(clk),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_pix_ready"}, int'(bus.pix_ready_o), 1);
      check({tag, "_wr_en"}, int'(bus.wr_en_o), 0);
      check({tag, "_rd_addr"}, int'(bus.rd_address_o), 0);
      check({tag, "_rd_sel"}, int'(bus.rd_sel_o), 0);
      check({tag, "_win_valid"}, int'(bus.win_valid_o), 0);
      check({tag, "_out_row"}, int'(bus.out_row_o), 0);
      check({tag, "_frame_done"}, int'(bus.frame_done_o), 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      bus.pix_valid_i = 1'b0;
      bus.win_ready_i = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_frame(input bit toggle);
      int sent = 0;
      int wins = 0;
      int er = 0;
      int ec = 0;
      int fd = 0;
      int fd_cyc = -1;
      int last_acc = -10;
      int tail = 0;
      for (int cyc = 0; cyc < 6000 && tail < 4; cyc++) begin
         @(negedge clk);
         bus.pix_valid_i = (sent < NPIX);
         bus.win_ready_i = toggle ? ((cyc & 1) == 1) : 1'b1;
         #1;
         if (bus.frame_done_o) begin
            fd++;
            fd_cyc = cyc;
         end
         if (bus.win_valid_o && bus.win_ready_i) begin
            check("win_col", int'(bus.rd_address_o), ec);
            check("win_row", int'(bus.out_row_o), er);
            check("win_sel", int'(bus.rd_sel_o), er % 4);
            wins++;
            last_acc = cyc;
            if (ec == IM_DIM - 3) begin
               ec = 0;
               er++;
            end else begin
               ec++;
            end
         end
         if (bus.pix_valid_i && bus.pix_ready_o) sent++;
         if (wins == NWIN) tail++;
      end
      check("frame_pixels", sent, NPIX);
      check("frame_windows", wins, NWIN);
      check("frame_done_count", fd, 1);
      check("frame_done_cycle", fd_cyc, last_acc + 1);
      check("frame_f_empty", int'(dut.f_q), 0);
   endtask

   initial begin
      int acc;
      int viol;
      bit hit;

      bus.pix_valid_i = 1'b0;
      bus.win_ready_i = 1'b0;
      #1;
      check_reset_outs("por");

      // Fill three lines, then align the 4th line with the row-0 end.
      @(negedge clk);
      reset = 1'b0;
      for (int cyc = 1; cyc <= 113; cyc++) begin
         @(negedge clk);
         bus.pix_valid_i = (cyc <= 112);
         bus.win_ready_i = (cyc != 86);
         #1;
         if (cyc <= 112)
            check("fill_wr_en", int'(bus.wr_en_o), 1 << ((cyc - 1) / 28));
         if (cyc == 85)
            check("fill_win_valid_pre", int'(bus.win_valid_o), 0);
         if (cyc == 86)
            check("fill_win_valid_rise", int'(bus.win_valid_o), 1);
         if (cyc >= 87 && cyc <= 112) begin
            check("row0_col", int'(bus.rd_address_o), cyc - 87);
            check("row0_row", int'(bus.out_row_o), 0);
            check("row0_sel", int'(bus.rd_sel_o), 0);
         end
         if (cyc == 113) begin
            check("align_f", int'(dut.f_q), 3);
            check("align_wr_ptr", int'(dut.wr_ptr_q), 0);
            check("align_rd_ptr", int'(dut.rd_ptr_q), 1);
            check("align_rd_sel", int'(bus.rd_sel_o), 1);
            check("align_out_row", int'(bus.out_row_o), 1);
            check("align_win_valid", int'(bus.win_valid_o), 0);
         end
      end

      // Walk row 1 to column 10, then reset between clock edges.
      hit = 1'b0;
      bus.pix_valid_i = 1'b0;
      for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
         @(negedge clk);
         bus.win_ready_i = 1'b1;
         #1;
         if (bus.win_valid_o && bus.rd_address_o == 10) hit = 1'b1;
      end
      check("midrow_reached", int'(hit), 1);
      check("midrow_row_pre", int'(bus.out_row_o), 1);
      bus.win_ready_i = 1'b0;
      bus.pix_valid_i = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check_reset_outs("async");
      @(negedge clk);
      bus.pix_valid_i = 1'b0;
      reset = 1'b0;

      run_frame(1'b0);

      pulse_reset();
      run_frame(1'b1);

      // Stall the consumer while the source keeps pushing.
      pulse_reset();
      acc = 0;
      viol = 0;
      for (int cyc = 0; cyc < 130; cyc++) begin
         @(negedge clk);
         bus.pix_valid_i = 1'b1;
         bus.win_ready_i = 1'b0;
         #1;
         if (bus.pix_valid_i && bus.pix_ready_o) acc++;
         if (!bus.pix_ready_o && bus.wr_en_o != '0) viol++;
      end
      check("stall_accepts", acc, 112);
      check("stall_f", int'(dut.f_q), 4);
      check("stall_pix_ready", int'(bus.pix_ready_o), 0);
      check("stall_wr_en", int'(bus.wr_en_o), 0);
      check("stall_wr_viol", viol, 0);
      check("stall_win_valid", int'(bus.win_valid_o), 1);
      check("stall_rd_addr", int'(bus.rd_address_o), 0);
      check("stall_out_row", int'(bus.out_row_o), 0);
      check("stall_rd_sel", int'(bus.rd_sel_o), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
